// File: rtl/im_program_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
package im_loader_pkg;

  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_INSTR_W = 15;
  localparam int DEF_DEPTH   = 128;
  localparam int OPCODE_W    = 7;
  localparam int LIT_W       = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } loader_state_e;

endpackage

// File: rtl/im_program_loader_if.sv
// Byte-stream input, IM write port and CPU status signals of the program loader.
interface im_program_loader_if
  import im_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic               start;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;
  logic               cpu_hold;
  logic               load_done;
  logic               load_err;
  logic [7:0]         word_count;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, word_count
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, word_count
  );

endinterface

// File: rtl/im_program_loader.sv
// Assembles LEN/(HI,LO)* byte streams into 15-bit IM words and holds the CPU until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module im_program_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  im_program_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_LEN   = LEN;
  localparam logic [2:0] S_HI    = HI;
  localparam logic [2:0] S_LO    = LO;
  localparam logic [2:0] S_WRITE = WRITE;
  localparam logic [2:0] S_CHK   = CHK;
  localparam logic [2:0] S_DONE  = DONE;
  localparam logic [2:0] S_ERR   = ERR;

  logic [2:0]          state;
  logic [7:0]          n_words;
  logic [OPCODE_W-1:0] opcode;
  logic [7:0]          word_count;
  logic [ADDR_W-1:0]   im_addr;
  logic [INSTR_W-1:0]  im_wdata;
  logic                cpu_hold;
  logic                load_done;
  logic                load_err;
  logic                in_ready;
  logic                take;
  logic [7:0]          next_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          chk_acc;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_LEN, S_HI, S_LO: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:             in_ready = 1'b1;
`endif
      default:           in_ready = 1'b0;
    endcase
  end

  assign take       = in_ready && bus.in_valid;
  assign next_count = word_count + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      n_words    <= '0;
      opcode     <= '0;
      word_count <= '0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_acc    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            state      <= S_LEN;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            cpu_hold   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            chk_acc    <= '0;
`endif
          end
        end
        S_LEN: begin
          if (take) begin
            if (bus.in_data == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state     <= S_CHK;
`else
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
`endif
            end else if ({1'b0, bus.in_data} > 9'(DEPTH)) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              n_words <= bus.in_data;
              state   <= S_HI;
            end
          end
        end
        S_HI: begin
          if (take) begin
            if (bus.in_data[7]) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              opcode <= bus.in_data[OPCODE_W-1:0];
              state  <= S_LO;
`ifdef LOADER_CHECKSUM_EN
              chk_acc <= chk_acc ^ bus.in_data;
`endif
            end
          end
        end
        S_LO: begin
          // Address and data are registered here so they stay stable after the write pulse.
          if (take) begin
            im_addr  <= word_count[ADDR_W-1:0];
            im_wdata <= INSTR_W'({opcode, bus.in_data[LIT_W-1:0]});
            state    <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
            chk_acc  <= chk_acc ^ bus.in_data;
`endif
          end
        end
        S_WRITE: begin
          word_count <= next_count;
          if (next_count == n_words) begin
`ifdef LOADER_CHECKSUM_EN
            state     <= S_CHK;
`else
            state     <= S_DONE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
`endif
          end else begin
            state <= S_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (take) begin
            if (bus.in_data == chk_acc) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.im_we      = (state == S_WRITE);
  assign bus.im_addr    = im_addr;
  assign bus.im_wdata   = im_wdata;
  assign bus.cpu_hold   = cpu_hold;
  assign bus.load_done  = load_done;
  assign bus.load_err   = load_err;
  assign bus.word_count = word_count;

endmodule

// File: tb/tb_im_program_loader.sv
// Table-driven, scoreboard-checked bench for im_program_loader (checksum byte sent when LOADER_CHECKSUM_EN is defined).
module tb_im_program_loader;

  typedef struct packed {
    logic [71:0] stream;
    logic [7:0]  nbytes;
    logic        gaps;
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  exp_count;
  } vec_t;

  logic clk;
  logic rst_n;

  im_program_loader_if #(.ADDR_W(7), .INSTR_W(15)) bus ();

  im_program_loader #(.ADDR_W(7), .INSTR_W(15), .DEPTH(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [21:0] exp_q[$];
  logic [6:0]  last_addr = '0;
  logic [14:0] last_data = '0;
  vec_t vecs[5];

  function automatic vec_t mk_vec(input logic [71:0] s, input int nb, input bit g,
                                  input bit d, input bit e, input int cnt);
    vec_t v;
    v.stream    = s;
    v.nbytes    = 8'(nb);
    v.gaps      = g;
    v.exp_done  = d;
    v.exp_err   = e;
    v.exp_count = 8'(cnt);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Every wait goes through here so write pulses are scored wherever they occur.
  task automatic tick();
    logic [21:0] e;
    @(negedge clk);
    if (rst_n && bus.im_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected im_we", int'(bus.im_we), 0);
      end else begin
        e = exp_q.pop_front();
        check("im_addr", int'(bus.im_addr), int'(e[21:15]));
        check("im_wdata", int'(bus.im_wdata), int'(e[14:0]));
      end
    end
  endtask

  task automatic push_write(input logic [6:0] addr, input logic [14:0] data);
    exp_q.push_back({addr, data});
    last_addr = addr;
    last_data = data;
  endtask

  task automatic apply_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit accepted;
    accepted = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        tick();
      end
    end
    bus.in_data = b;
    for (int k = 0; k < 40; k++) begin
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.in_ready && bus.in_valid) accepted = 1'b1;
      tick();
      if (accepted) break;
    end
    bus.in_valid = 1'b0;
    if (!accepted) check("in_ready timeout", int'(bus.in_ready), 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] b;
    logic [7:0] hi;
    logic [7:0] chk;
    hi  = '0;
    chk = '0;
    apply_start();
    for (int i = 0; i < int'(v.nbytes); i++) begin
      b = v.stream[71-8*i -: 8];
      if (i > 0) begin
        chk = chk ^ b;
        if (i % 2 == 1) hi = b;
        else push_write(7'((i / 2) - 1), {hi[6:0], b});
      end
      send_byte(b, v.gaps);
    end
`ifdef LOADER_CHECKSUM_EN
    if (!v.exp_err) send_byte(chk, v.gaps);
`endif
    repeat (4) tick();
  endtask

  task automatic checkOutput(input vec_t v);
    check("load_done", int'(bus.load_done), int'(v.exp_done));
    check("load_err", int'(bus.load_err), int'(v.exp_err));
    check("cpu_hold", int'(bus.cpu_hold), int'(!v.exp_done));
    check("word_count", int'(bus.word_count), int'(v.exp_count));
    check("in_ready idle", int'(bus.in_ready), 0);
    check("pending writes", exp_q.size(), 0);
    check("im_addr hold", int'(bus.im_addr), int'(last_addr));
    check("im_wdata hold", int'(bus.im_wdata), int'(last_data));
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst cpu_hold", int'(bus.cpu_hold), 1);
    check("rst load_done", int'(bus.load_done), 0);
    check("rst load_err", int'(bus.load_err), 0);
    check("rst word_count", int'(bus.word_count), 0);
    check("rst im_we", int'(bus.im_we), 0);
    check("rst im_addr", int'(bus.im_addr), 0);
    check("rst im_wdata", int'(bus.im_wdata), 0);
    check("rst in_ready", int'(bus.in_ready), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] chk;
    logic [7:0] hi;
    logic [7:0] lo;
    vec_t v;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    vecs[0] = mk_vec(72'h03_02_05_03_0A_04_00_00_00, 7, 1'b0, 1'b1, 1'b0, 3);
    vecs[1] = mk_vec(72'h00_00_00_00_00_00_00_00_00, 1, 1'b0, 1'b1, 1'b0, 0);
    vecs[2] = mk_vec(72'h81_00_00_00_00_00_00_00_00, 1, 1'b0, 1'b0, 1'b1, 0);
    vecs[3] = mk_vec(72'h02_01_11_85_00_00_00_00_00, 4, 1'b0, 1'b0, 1'b1, 1);
    vecs[4] = mk_vec(72'h04_10_20_11_21_12_22_7F_FF, 9, 1'b1, 1'b1, 1'b0, 4);

    tick();
    tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();
    check_reset_values();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // start pulsed mid-word must be ignored
    apply_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    push_write(7'd0, {7'h01, 8'h02});
    send_byte(8'h02, 1'b0);
    push_write(7'd1, {7'h03, 8'h04});
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 1'b0);
`endif
    repeat (4) tick();
    checkOutput(mk_vec('0, 0, 1'b0, 1'b1, 1'b0, 2));

    // full-depth session: 128 words, last address 127
    apply_start();
    chk = '0;
    send_byte(8'h80, 1'b0);
    for (int i = 0; i < 128; i++) begin
      hi = 8'(i) & 8'h7F;
      lo = 8'(i * 5 + 3);
      chk = chk ^ hi ^ lo;
      push_write(7'(i), {hi[6:0], lo});
      send_byte(hi, 1'b0);
      send_byte(lo, 1'b0);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk, 1'b0);
`endif
    repeat (4) tick();
    check("full last addr", int'(last_addr), 127);
    checkOutput(mk_vec('0, 0, 1'b0, 1'b1, 1'b0, 128));

    // asynchronous reset after one of three words
    apply_start();
    send_byte(8'h03, 1'b0);
    push_write(7'd0, {7'h01, 8'h02});
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    check("pre-reset word_count", int'(bus.word_count), 1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    last_addr = '0;
    last_data = '0;
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(vecs[0]);
    checkOutput(vecs[0]);

`ifdef LOADER_CHECKSUM_EN
    // wrong checksum aborts but keeps the written word
    apply_start();
    send_byte(8'h01, 1'b0);
    push_write(7'd0, {7'h01, 8'h02});
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hFF, 1'b0);
    repeat (4) tick();
    checkOutput(mk_vec('0, 0, 1'b0, 1'b0, 1'b1, 1));
`endif

    v = vecs[1];
    applyStimulus(v);
    checkOutput(v);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/im_program_loader.md
Name: im_program_loader

Overview:
Writer side of the 15-bit instruction memory that the CPU's PC/decoder reads. It accepts a byte stream over a valid/ready interface and assembles {opcode[6:0], literal[7:0]} words. Words are written to consecutive IM addresses starting at 0. The CPU is held in stall (cpu_hold) until a complete, well-formed program has been written.

Parameters:
ADDR_W, 7, IM address width (matches 7-bit PC)
INSTR_W, 15, instruction width (7b opcode + 8b literal)
DEPTH, 128, max words; must equal 2**ADDR_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
start  in  1  pulse: begin new load session
in_valid  in  1  byte on in_data is valid
in_data  in  8  stream byte
in_ready  out  1  loader accepts byte this cycle
im_we  out  1  IM write enable, one-cycle pulse per word
im_addr  out  ADDR_W  IM write address
im_wdata  out  INSTR_W  IM write data
cpu_hold  out  1  1 = CPU PC/registers must not advance
load_done  out  1  level: last session completed without error
load_err  out  1  level: last session aborted on error
word_count  out  8  words written in current/last session

Behaviour:
- Reset values: all outputs 0, except cpu_hold=1. State=IDLE.
- Byte transfer occurs only on cycles where in_valid && in_ready. in_data is ignored otherwise. in_valid may drop at any time with no effect.
- Stream format: LEN byte N, then N pairs (HI, LO). HI[7] must be 0; HI[6:0]=opcode. LO=literal.
- States and transitions:
  - IDLE: in_ready=0. On start -> LEN, word_count<=0, load_done<=0, load_err<=0, cpu_hold<=1.
  - LEN: in_ready=1. On accept: N==0 -> DONE. N>DEPTH -> ERR. Otherwise latch N -> HI.
  - HI: in_ready=1. On accept: bit7=1 -> ERR. Otherwise latch opcode -> LO.
  - LO: in_ready=1. On accept: latch literal -> WRITE.
  - WRITE: in_ready=0. im_we=1 for exactly this cycle, im_addr=word_count[ADDR_W-1:0], im_wdata={opcode,literal}. Then word_count+1. If word_count+1==N -> DONE (or CHK, see Optional Feature); else -> HI.
  - DONE: load_done=1, cpu_hold=0, in_ready=0.
  - ERR: load_err=1, cpu_hold=1, in_ready=0. No IM writes.
- Latency: LO byte accepted at edge t; im_we high during cycle t+1; in_ready high again in cycle t+2. Peak throughput is 1 word per 3 cycles.
- start is honoured only in IDLE, DONE and ERR. It is ignored in LEN/HI/LO/WRITE/CHK.
- start in DONE re-asserts cpu_hold on the next cycle and re-loads from address 0.
- N==DEPTH (128): last write goes to address 127 and word_count reaches 128. Address never wraps within a session.
- im_addr/im_wdata hold their last values when im_we=0.
- Asynchronous reset mid-session: immediately returns to reset values. IM contents are left partially written; cpu_hold=1 until a successful reload.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: after the last WRITE, go to state CHK (in_ready=1) and accept one byte. It must equal the XOR of all HI and LO bytes of the session (0x00 when N=0, in which case LEN -> CHK). Match -> DONE; mismatch -> ERR. Words already written stay in IM.
- Undefined: no CHK state. WRITE/LEN go straight to DONE as described above.

Decomposition:
- Package im_loader_pkg holds:
  - state enum (IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR)
  - ADDR_W/INSTR_W/DEPTH defaults
  - OPCODE_W=7, LIT_W=8
- Single flat module; FSM plus small datapath. No sub-module warranted.

Test Plan:
- start; stream 03, 02,05, 03,0A, 04,00 with in_valid held high -> im_we pulses at addr 0,1,2 with wdata 0x0205, 0x030A, 0x0400; word_count=3; load_done=1; cpu_hold=0.
- start; LEN=00 -> DONE immediately, no im_we, word_count=0, cpu_hold=0.
- LEN=0x81 (129) -> load_err=1, cpu_hold=1, no im_we. A following start recovers.
- N=2, second HI byte 0x85 -> ERR after exactly one write (addr 0). load_err=1.
- Toggle in_valid randomly during a 4-word load -> identical writes to the gapless case. No byte is taken while in_ready=0.
- Assert rst_n=0 after 1 of 3 words -> outputs reset, cpu_hold=1. Next full session writes from addr 0. With LOADER_CHECKSUM_EN, a wrong checksum byte -> load_err=1.
